// File: rtl/c432_irq_pkg.sv
// Shared types and constants for the c432 interrupt sequencer.
// Optional ack timeout is enabled by defining IRQ_ACK_TIMEOUT_EN.
package c432_irq_pkg;

    localparam int NCH_DEF = 9;
    localparam int CHW     = 4;

    localparam logic [1:0] BUS_A = 2'd0;
    localparam logic [1:0] BUS_B = 2'd1;
    localparam logic [1:0] BUS_C = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        PRESENT,
        SERVICE
    } state_t;

endpackage

// File: rtl/c432_prio_resolve.sv
// 27-channel priority resolver: bus A over B over C, lower index first.
// Purely combinational so it can be replaced by the optimised netlist.
module c432_prio_resolve
    import c432_irq_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic [NCH-1:0] ma,
    input  logic [NCH-1:0] mb,
    input  logic [NCH-1:0] mc,
    output logic           found,
    output logic [1:0]     bus,
    output logic [CHW-1:0] chan
);

    // Scan lowest priority first so later hits override earlier ones.
    always_comb begin
        found = 1'b0;
        bus   = BUS_A;
        chan  = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mc[i]) begin
                found = 1'b1;
                bus   = BUS_C;
                chan  = CHW'(i);
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mb[i]) begin
                found = 1'b1;
                bus   = BUS_B;
                chan  = CHW'(i);
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ma[i]) begin
                found = 1'b1;
                bus   = BUS_A;
                chan  = CHW'(i);
            end
        end
    end

endmodule

// File: rtl/c432_irq_sequencer.sv
// Interrupt sequencer: pending capture, priority resolve, valid/ack, EOI.
// Define IRQ_ACK_TIMEOUT_EN to add the ack timeout and tmo_flag output.
module c432_irq_sequencer
    import c432_irq_pkg::*;
#(
    parameter int NCH = NCH_DEF
`ifdef IRQ_ACK_TIMEOUT_EN
    ,
    parameter int TMO_W = 8
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req_a,
    input  logic [NCH-1:0] req_b,
    input  logic [NCH-1:0] req_c,
    input  logic [NCH-1:0] en,
    output logic           irq_valid,
    output logic [1:0]     irq_bus,
    output logic [CHW-1:0] irq_chan,
    input  logic           irq_ack,
    input  logic           eoi,
    output logic           busy,
`ifdef IRQ_ACK_TIMEOUT_EN
    output logic           tmo_flag,
`endif
    output logic           pend_any
);

    state_t state, nstate;

    logic [NCH-1:0] pend_a, pend_b, pend_c;
    logic [NCH-1:0] ma, mb, mc;
    logic [NCH-1:0] sel;
    logic [NCH-1:0] clr_a, clr_b, clr_c;
    logic           found;
    logic [1:0]     wbus;
    logic [CHW-1:0] wchan;
    logic           take;
    logic           tmo_hit;

    assign ma       = pend_a & en;
    assign mb       = pend_b & en;
    assign mc       = pend_c & en;
    assign pend_any = |{ma, mb, mc};

    assign take = (state == PRESENT) && irq_ack;
    assign sel  = {{(NCH-1){1'b0}}, 1'b1} << irq_chan;

    assign clr_a = (take && irq_bus == BUS_A) ? sel : '0;
    assign clr_b = (take && irq_bus == BUS_B) ? sel : '0;
    assign clr_c = (take && irq_bus == BUS_C) ? sel : '0;

    c432_prio_resolve #(
        .NCH (NCH)
    ) u_res (
        .ma    (ma),
        .mb    (mb),
        .mc    (mc),
        .found (found),
        .bus   (wbus),
        .chan  (wchan)
    );

    // A request on the same cycle as its ack keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_a <= '0;
            pend_b <= '0;
            pend_c <= '0;
        end else begin
            pend_a <= (pend_a & ~clr_a) | req_a;
            pend_b <= (pend_b & ~clr_b) | req_b;
            pend_c <= (pend_c & ~clr_c) | req_c;
        end
    end

`ifdef IRQ_ACK_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_hit = (state == PRESENT) && !irq_ack && (&tmo_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (state == RESOLVE) begin
                tmo_cnt <= '0;
            end else if (state == PRESENT && !irq_ack) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (tmo_hit) begin
                tmo_flag <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (pend_any) nstate = RESOLVE;
            RESOLVE: nstate = found ? PRESENT : IDLE;
            PRESENT: begin
                if (take)         nstate = SERVICE;
                else if (tmo_hit) nstate = IDLE;
            end
            SERVICE: if (eoi) nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            irq_bus  <= BUS_A;
            irq_chan <= '0;
        end else begin
            state <= nstate;
            if (state == RESOLVE && found) begin
                irq_bus  <= wbus;
                irq_chan <= wchan;
            end
        end
    end

    assign irq_valid = (state == PRESENT);
    assign busy      = (state != IDLE);

endmodule
